// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/execute controller: fetches ROM instructions, drives the
// register file, the ALU opcode, COND branches and the valid/ready I/O ports.
// Ports: clock/reset, run, pc/instr (ROM), rf_* (register file), cond_operand,
// alu_op/alu_y, in_* and out_* handshakes, halted.
module instruction_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [7:0]            instr,
  output logic                  rf_save,
  output logic [2:0]            rf_saveselector,
  output logic [DATA_WIDTH-1:0] rf_savebus,
  output logic [2:0]            rf_loadselector,
  input  logic [DATA_WIDTH-1:0] rf_loadbus,
  input  logic [DATA_WIDTH-1:0] cond_operand,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_y,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  halted
);

  typedef enum logic [2:0] {
    IDLE, FETCH, EXECUTE, WAIT_IN, WAIT_OUT, HALT
  } state_t;

  state_t                state, next_state;
  logic [7:0]            ir;
  logic [PC_WIDTH-1:0]   pc_next, pc_inc;
  logic                  out_load;
  logic [DATA_WIDTH-1:0] out_next;
  logic                  done;
  logic                  zero, neg, hit, taken;
  logic [2:0]            src, dst;

  assign src    = ir[5:3];
  assign dst    = ir[2:0];
  assign pc_inc = pc + PC_WIDTH'(1);

  // Handshake strobes follow the state directly, so reset clears them at once.
  assign in_ready  = (state == WAIT_IN);
  assign out_valid = (state == WAIT_OUT);
  assign halted    = (state == HALT);

  // ir[2] inverts the base test: never, ==0, <0, <=0.
  always_comb begin
    zero = (cond_operand == '0);
    neg  = cond_operand[DATA_WIDTH-1];
    hit  = 1'b0;
    unique case (ir[1:0])
      2'd0: hit = 1'b0;
      2'd1: hit = zero;
      2'd2: hit = neg;
      2'd3: hit = neg | zero;
    endcase
    taken = hit ^ ir[2];
  end

  always_comb begin
    next_state      = state;
    pc_next         = pc;
    out_load        = 1'b0;
    out_next        = out_data;
    rf_save         = 1'b0;
    rf_saveselector = 3'd0;
    rf_savebus      = '0;
    rf_loadselector = 3'd0;
    alu_op          = 3'd0;
    done            = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: next_state = EXECUTE;
      EXECUTE: begin
        unique case (ir[7:6])
          2'b00: begin
            rf_save    = 1'b1;
            rf_savebus = DATA_WIDTH'(ir[5:0]);
            pc_next    = pc_inc;
            done       = 1'b1;
          end
          2'b01: begin
            alu_op          = ir[2:0];
            rf_save         = 1'b1;
            rf_saveselector = 3'd3;
            rf_savebus      = alu_y;
            pc_next         = pc_inc;
            done            = 1'b1;
          end
          2'b10: begin
            if (src == 3'd7 || dst == 3'd7) begin
              next_state = HALT;
            end else if (src == 3'd6) begin
              next_state = WAIT_IN;
            end else begin
              rf_loadselector = src;
              if (dst == 3'd6) begin
                out_load   = 1'b1;
                out_next   = rf_loadbus;
                next_state = WAIT_OUT;
              end else begin
                rf_save         = 1'b1;
                rf_saveselector = dst;
                rf_savebus      = rf_loadbus;
                pc_next         = pc_inc;
                done            = 1'b1;
              end
            end
          end
          2'b11: begin
            pc_next = taken ? PC_WIDTH'(rf_loadbus) : pc_inc;
            done    = 1'b1;
          end
        endcase
      end
      WAIT_IN: begin
        if (in_valid) begin
          if (dst == 3'd6) begin
            out_load   = 1'b1;
            out_next   = in_data;
            next_state = WAIT_OUT;
          end else begin
            rf_save         = 1'b1;
            rf_saveselector = dst;
            rf_savebus      = in_data;
            pc_next         = pc_inc;
            done            = 1'b1;
          end
        end
      end
      WAIT_OUT: begin
        if (out_ready) begin
          pc_next = pc_inc;
          done    = 1'b1;
        end
      end
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
    if (done) next_state = run ? FETCH : IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= PC_WIDTH'(RESET_PC);
      ir       <= 8'd0;
      out_data <= '0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (state == FETCH) ir <= instr;
      if (out_load) out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a behavioural ROM and
// register file; expected values are hand-computed per scenario.
module tb_instruction_sequencer;

  logic       clock, reset, run;
  logic [7:0] pc, instr;
  logic       rf_save;
  logic [2:0] rf_saveselector, rf_loadselector, alu_op;
  logic [7:0] rf_savebus, rf_loadbus, cond_operand, alu_y;
  logic [7:0] in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready, halted;

  logic [7:0] rom [0:255];
  logic [7:0] regs [0:7];
  logic [7:0] r0_init;
  logic       cond_ovr_en;
  logic [7:0] cond_ovr;
  int         savecnt;
  int         errors, checks;

  instruction_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .pc(pc), .instr(instr),
    .rf_save(rf_save), .rf_saveselector(rf_saveselector),
    .rf_savebus(rf_savebus), .rf_loadselector(rf_loadselector),
    .rf_loadbus(rf_loadbus), .cond_operand(cond_operand),
    .alu_op(alu_op), .alu_y(alu_y), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign instr        = rom[pc];
  assign rf_loadbus   = (rf_loadselector < 3'd6) ? regs[rf_loadselector] : 8'd0;
  assign cond_operand = cond_ovr_en ? cond_ovr : regs[3];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
      regs[0] <= r0_init;
      savecnt <= 0;
    end else if (rf_save) begin
      if (rf_saveselector < 3'd6) regs[rf_saveselector] <= rf_savebus;
      savecnt <= savecnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    run         = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'd0;
    out_ready   = 1'b0;
    cond_ovr_en = 1'b0;
    cond_ovr    = 8'd0;
    alu_y       = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    r0_init = 8'd0;

    // 1: async reset in WAIT_OUT, then restart from pc 0
    r0_init = 8'h77;
    do_reset();
    rom[0] = 8'h86;
    run = 1'b1;
    tick(3);
    check("t1_ov_before", out_valid, 1);
    check("t1_od_before", out_data, 8'h77);
    #2 reset = 1'b0;
    #1;
    check("t1_ov_rst", out_valid, 0);
    check("t1_pc_rst", pc, 0);
    check("t1_od_rst", out_data, 0);
    check("t1_strobes", {rf_save, in_ready, halted}, 0);
    check("t1_sels", {rf_saveselector, rf_loadselector, alu_op}, 0);
    @(negedge clock);
    reset = 1'b1;
    tick(2);
    check("t1_restart_ex", rf_save, 0);
    tick(1);
    check("t1_restart_ov", out_valid, 1);
    check("t1_restart_pc", pc, 0);

    // 2: IMM 5 then COPY 0->1
    r0_init = 8'd0;
    do_reset();
    rom[0] = 8'h05;
    rom[1] = 8'h81;
    run = 1'b1;
    tick(1);
    check("t2_fetch_save", rf_save, 0);
    tick(1);
    check("t2_imm_save", {rf_save, rf_saveselector}, {1'b1, 3'd0});
    check("t2_imm_bus", rf_savebus, 8'h05);
    tick(1);
    check("t2_pc1", pc, 1);
    run = 1'b0;
    tick(1);
    check("t2_cp_save", {rf_save, rf_saveselector}, {1'b1, 3'd1});
    tick(3);
    check("t2_pc2", pc, 2);
    check("t2_r0", regs[0], 8'h05);
    check("t2_r1", regs[1], 8'h05);
    check("t2_saves", savecnt, 2);

    // 3: IMM 3; COPY 0->1; COPY 0->2; CALC op 4
    do_reset();
    rom[0] = 8'h03;
    rom[1] = 8'h81;
    rom[2] = 8'h82;
    rom[3] = 8'h44;
    alu_y  = 8'h06;
    run = 1'b1;
    tick(7);
    run = 1'b0;
    tick(1);
    check("t3_alu_op", alu_op, 4);
    check("t3_save", {rf_save, rf_saveselector}, {1'b1, 3'd3});
    check("t3_bus", rf_savebus, 8'h06);
    tick(1);
    check("t3_pc", pc, 4);
    check("t3_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'h03030306);
    check("t3_saves", savecnt, 4);

    // 4: COND branches and pc wrap
    do_reset();
    cond_ovr_en = 1'b1;
    cond_ovr    = 8'h80;
    alu_y       = 8'hFF;
    rom[8'h00] = 8'h10;
    rom[8'h01] = 8'hC2;
    rom[8'h10] = 8'hC7;
    rom[8'h11] = 8'h40;
    rom[8'h12] = 8'h98;
    rom[8'h13] = 8'hC4;
    rom[8'hFF] = 8'hC0;
    run = 1'b1;
    tick(4);
    check("t4_cond_save", rf_save, 0);
    check("t4_cond_lsel", rf_loadselector, 0);
    tick(1);
    check("t4_taken_pc", pc, 8'h10);
    tick(2);
    check("t4_not_taken", pc, 8'h11);
    tick(6);
    check("t4_pc_ff", pc, 8'hFF);
    check("t4_r0", regs[0], 8'hFF);
    run = 1'b0;
    tick(2);
    check("t4_wrap", pc, 8'h00);
    check("t4_saves", savecnt, 3);

    // 5: COPY 6->6 with delayed in_valid and out_ready
    do_reset();
    rom[0] = 8'hB6;
    run = 1'b1;
    tick(3);
    check("t5_in_ready", in_ready, 1);
    tick(2);
    check("t5_in_wait", {in_ready, out_valid}, 2'b10);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick(1);
    in_valid = 1'b0;
    check("t5_ov", {out_valid, in_ready}, 2'b10);
    check("t5_od", out_data, 8'hA5);
    tick(1);
    check("t5_ov_held", out_valid, 1);
    check("t5_od_held", out_data, 8'hA5);
    check("t5_pc_hold", pc, 0);
    out_ready = 1'b1;
    run = 1'b0;
    tick(1);
    out_ready = 1'b0;
    check("t5_ov_done", out_valid, 0);
    check("t5_pc_done", pc, 1);
    check("t5_saves", savecnt, 0);

    // 6a: COPY 7->1 halts
    do_reset();
    rom[0] = 8'hB9;
    run = 1'b1;
    tick(3);
    check("t6_halted", halted, 1);
    tick(4);
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(2);
    check("t6_still_halt", halted, 1);
    check("t6_pc_frozen", pc, 0);
    check("t6_saves", savecnt, 0);

    // 6b: run dropped in WAIT_IN finishes the handshake then idles
    do_reset();
    rom[0] = 8'hB2;
    run = 1'b1;
    tick(3);
    run = 1'b0;
    tick(1);
    check("t6b_wait_in", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    check("t6b_save", {rf_save, rf_saveselector}, {1'b1, 3'd2});
    tick(1);
    in_valid = 1'b0;
    check("t6b_idle", in_ready, 0);
    check("t6b_pc", pc, 1);
    check("t6b_r2", regs[2], 8'h3C);
    tick(2);
    check("t6b_pc_kept", pc, 1);
    check("t6b_saves", savecnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
